// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage: FSM states, NOP word, field slices.
package fetch_stage_pkg;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } fetch_state_t;

    // sll $0,$0,0
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    function automatic logic [5:0] opcode_of(input logic [31:0] instr);
        return instr[31:26];
    endfunction

    function automatic logic [5:0] funct_of(input logic [31:0] instr);
        return instr[5:0];
    endfunction

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory port: valid/ready request channel plus valid-only response channel.
interface fetch_stage_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_resp_valid,
        input  imem_resp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_resp_valid,
        output imem_resp_data
    );
endinterface

// File: rtl/fetch_buffer.sv
// One-entry {instr, pc} holding register that catches a fetched word while IF/ID is stalled.
module fetch_buffer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        drain,
    input  logic        flush,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    output logic        full,
    output logic [31:0] instr,
    output logic [31:0] pc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full  <= 1'b0;
            instr <= '0;
            pc    <= '0;
        end else if (flush || drain) begin
            full <= 1'b0;
        end else if (load) begin
            full  <= 1'b1;
            instr <= in_instr;
            pc    <= in_pc;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction fetch stage: owns the PC, fetches from imem, fills the IF/ID register,
// applies downstream redirects and honours stalls.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = NOP_WORD
) (
    input  logic                clk,
    input  logic                rst_n,
    fetch_stage_if.master       imem,
    input  logic                stall,
    input  logic                redirect,
    input  logic [31:0]         redirect_pc,
    output logic                if_valid,
    output logic [31:0]         if_instr,
    output logic [31:0]         if_pc,
    output logic [31:0]         if_pc_plus4,
    output logic [5:0]          if_opcode,
    output logic [5:0]          if_funct,
    output logic                fetch_misalign
);

    fetch_state_t state;
    logic         started;
    logic         kill;
    logic [31:0]  pc;
    logic [31:0]  req_addr_q;
    logic [31:0]  pc_plus4;
    logic [31:0]  target;
    logic         resp_take;
    logic         back_to_back;
    logic         fire;
    logic         hold_drain;
    logic         buf_full;
    logic [31:0]  buf_instr;
    logic [31:0]  buf_pc;

    assign pc_plus4     = pc + 32'd4;
    assign target       = align_word(redirect_pc);
    assign resp_take    = (state == ST_WAIT) && imem.imem_resp_valid && !kill && !redirect;
    assign back_to_back = resp_take && !stall;
    assign hold_drain   = (state == ST_HOLD) && buf_full && !stall && !redirect;

    // A killed request keeps presenting its original address from req_addr_q while pc
    // already tracks the redirect target; the back-to-back request is pc+4.
    assign imem.imem_req_valid = started && ((state == ST_REQ) || back_to_back);
    assign imem.imem_req_addr  = (state == ST_REQ) ? req_addr_q : pc_plus4;
    assign fire                = imem.imem_req_valid && imem.imem_req_ready;

    fetch_buffer u_buffer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (resp_take && stall),
        .drain    (hold_drain),
        .flush    ((state == ST_HOLD) && redirect),
        .in_instr (imem.imem_resp_data),
        .in_pc    (pc),
        .full     (buf_full),
        .instr    (buf_instr),
        .pc       (buf_pc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_REQ;
            started        <= 1'b0;
            kill           <= 1'b0;
            pc             <= RESET_PC;
            req_addr_q     <= RESET_PC;
            fetch_misalign <= 1'b0;
        end else begin
            started        <= 1'b1;
            fetch_misalign <= redirect && (redirect_pc[1:0] != 2'b00);
            if (redirect)
                pc <= target;
            case (state)
                ST_REQ: begin
                    if (!started)
                        req_addr_q <= redirect ? target : pc;
                    if (redirect && started)
                        kill <= 1'b1;
                    if (fire)
                        state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (redirect) begin
                        if (imem.imem_resp_valid) begin
                            kill       <= 1'b0;
                            state      <= ST_REQ;
                            req_addr_q <= target;
                        end else begin
                            kill <= 1'b1;
                        end
                    end else if (imem.imem_resp_valid) begin
                        if (kill) begin
                            kill       <= 1'b0;
                            state      <= ST_REQ;
                            req_addr_q <= pc;
                        end else if (!stall) begin
                            pc <= pc_plus4;
                            if (!fire) begin
                                state      <= ST_REQ;
                                req_addr_q <= pc_plus4;
                            end
                        end else begin
                            pc    <= pc_plus4;
                            state <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (redirect) begin
                        state      <= ST_REQ;
                        req_addr_q <= target;
                    end else if (!stall) begin
                        state      <= ST_REQ;
                        req_addr_q <= pc;
                    end
                end
                default: state <= ST_REQ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_valid    <= 1'b0;
            if_instr    <= NOP_INSTR;
            if_pc       <= '0;
            if_pc_plus4 <= 32'd4;
        end else if (!stall) begin
            if (back_to_back) begin
                if_valid    <= 1'b1;
                if_instr    <= imem.imem_resp_data;
                if_pc       <= pc;
                if_pc_plus4 <= pc_plus4;
            end else if (hold_drain) begin
                if_valid    <= 1'b1;
                if_instr    <= buf_instr;
                if_pc       <= buf_pc;
                if_pc_plus4 <= buf_pc + 32'd4;
            end else begin
                if_valid <= 1'b0;
                if_instr <= NOP_INSTR;
            end
        end
    end

    assign if_opcode = opcode_of(if_instr);
    assign if_funct  = funct_of(if_instr);

endmodule
